// File: rtl/bsg_encode_pkg.sv
// Shared types and helpers for the serial bit-index encoder.
package bsg_encode_pkg;

  typedef enum logic {
    eIdle = 1'b0,
    eBusy = 1'b1
  } state_e;

  // clog2 with a floor of 1 so the index bus is never zero width
  function automatic int lg_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bsg_encode_lowest.sv
// Combinational lowest-set-bit priority encoder.
// Also reports the isolated lowest bit (for clearing) and whether exactly one bit is set.
module bsg_encode_lowest
  import bsg_encode_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0]              in_i,
  output logic [lg_width(width_p)-1:0]    index_o,
  output logic [width_p-1:0]              one_hot_o,
  output logic                            single_o
);

  localparam int lg_width_lp = lg_width(width_p);

  // lowest set bit wins; all-zero input yields index 0
  always_comb begin
    logic found;
    found   = 1'b0;
    index_o = '0;
    for (int unsigned k = 0; k < width_p; k++) begin
      if (in_i[k] && !found) begin
        index_o = lg_width_lp'(k);
        found   = 1'b1;
      end
    end
  end

  // isolate the lowest bit and detect a power-of-two mask
  always_comb begin
    one_hot_o = in_i & (~in_i + width_p'(1));
    single_o  = ((in_i & (in_i - width_p'(1))) == '0) && (in_i != '0);
  end

endmodule

// File: rtl/bsg_encode_serial.sv
// Serial encoder: accepts a bit vector and emits the index of each set bit,
// lowest first, one per yumi handshake.
module bsg_encode_serial
  import bsg_encode_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [width_p-1:0]              i,
  input  logic                            v_i,
  output logic                            ready_o,
  output logic [lg_width(width_p)-1:0]    index_o,
  output logic                            v_o,
  output logic                            last_o,
  input  logic                            yumi_i
);

  localparam int lg_width_lp = lg_width(width_p);

  state_e               state_q;
  logic [width_p-1:0]   mask_q;
  logic [width_p-1:0]   one_hot;
  logic [lg_width_lp-1:0] low_index;
  logic                 single;

  bsg_encode_lowest #(
    .width_p (width_p)
  ) lowest (
    .in_i      (mask_q),
    .index_o   (low_index),
    .one_hot_o (one_hot),
    .single_o  (single)
  );

  // state and remaining-mask register; a zero vector is swallowed without leaving idle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      mask_q  <= '0;
    end else begin
      case (state_q)
        eIdle: begin
          if (v_i && (i != '0)) begin
            mask_q  <= i;
            state_q <= eBusy;
          end
        end
        eBusy: begin
          if (yumi_i) begin
            mask_q <= mask_q & ~one_hot;
            if (single) state_q <= eIdle;
          end
        end
        default: begin
          state_q <= eIdle;
          mask_q  <= '0;
        end
      endcase
    end
  end

  // outputs decode only registered state, so no input reaches them combinationally;
  // mask_q is zero whenever idle, which forces index_o and last_o low there
  always_comb begin
    ready_o = (state_q == eIdle);
    v_o     = (state_q == eBusy);
    index_o = low_index;
    last_o  = single && (state_q == eBusy);
  end

endmodule

// File: tb/tb_bsg_encode_serial.sv
// Self-checking bench for bsg_encode_serial at width 32 and width 7.
module tb_bsg_encode_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] i32 = '0;
  logic        v32 = 1'b0, yumi32 = 1'b0;
  logic        ready32, vo32, last32;
  logic [4:0]  idx32;

  logic [6:0]  i7 = '0;
  logic        v7 = 1'b0, yumi7 = 1'b0;
  logic        ready7, vo7, last7;
  logic [2:0]  idx7;

  bsg_encode_serial #(.width_p(32)) dut32 (
    .clk_i(clk), .reset_i(rst), .i(i32), .v_i(v32), .ready_o(ready32),
    .index_o(idx32), .v_o(vo32), .last_o(last32), .yumi_i(yumi32)
  );

  bsg_encode_serial #(.width_p(7)) dut7 (
    .clk_i(clk), .reset_i(rst), .i(i7), .v_i(v7), .ready_o(ready7),
    .index_o(idx7), .v_o(vo7), .last_o(last7), .yumi_i(yumi7)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] sb32[$];
  logic [31:0] sb7[$];

  typedef struct {
    logic [31:0] vec;
    int          first;
    int          count;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s actual=timeout required=progress", name);
  endtask

  // consumer must never yumi without valid
  always @(negedge clk) begin
    if (!rst && yumi32 && !vo32) begin checks++; $display("FAIL yumi32_illegal actual=1 required=0"); end
    if (!rst && yumi7 && !vo7)   begin checks++; $display("FAIL yumi7_illegal actual=1 required=0"); end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit sel, input logic [31:0] vec);
    int b;
    logic [31:0] m;
    b = 0;
    m = sel ? (vec & 32'h7f) : vec;
    while (!(sel ? ready7 : ready32) && b < 100) begin step(); b++; end
    if (b >= 100) fail("send_timeout");
    if (sel) begin v7 = 1'b1; i7 = m[6:0]; end
    else     begin v32 = 1'b1; i32 = m; end
    step();
    v7 = 1'b0; v32 = 1'b0;
    if (m != '0) begin
      if (sel) sb7.push_back(m); else sb32.push_back(m);
    end
  endtask

  // pop every index of the oldest pending vector, rebuilding it from the indices
  task automatic drain(input bit sel, input int max_gap, output int n, output int first);
    logic [31:0] acc, exp, bitv;
    int prev, budget, idx;
    bit done, vo, last;
    n = 0; first = -1; acc = '0; prev = -1; budget = 0; done = 0;
    if ((sel ? sb7.size() : sb32.size()) == 0) begin fail("sb_empty"); return; end
    exp = sel ? sb7[0] : sb32[0];
    while (!done && budget < 400) begin
      vo   = sel ? vo7 : vo32;
      idx  = sel ? int'(idx7) : int'(idx32);
      last = sel ? last7 : last32;
      if (vo && (max_gap == 0 || $urandom_range(max_gap, 0) == 0)) begin
        bitv = 32'd1 << idx;
        chk("ascending", 32'(idx > prev), 32'd1);
        chk("last_flag", 32'(last), 32'((acc | bitv) == exp));
        if (n == 0) first = idx;
        acc |= bitv; prev = idx; n++;
        if (last) done = 1;
        if (sel) yumi7 = 1'b1; else yumi32 = 1'b1;
      end else begin
        yumi7 = 1'b0; yumi32 = 1'b0;
      end
      step();
      budget++;
    end
    yumi7 = 1'b0; yumi32 = 1'b0;
    if (!done) fail("drain_timeout");
    if (sel) void'(sb7.pop_front()); else void'(sb32.pop_front());
    chk("rebuild", acc, exp);
    chk("ready_after", 32'(sel ? ready7 : ready32), 32'd1);
  endtask

  initial begin
    int n, f;
    logic [31:0] vec;

    tbl[0] = '{32'h0000_0001, 0, 1};
    tbl[1] = '{32'h8000_0000, 31, 1};
    tbl[2] = '{32'hAAAA_AAAA, 1, 16};
    tbl[3] = '{32'h0000_00F0, 4, 4};
    tbl[4] = '{32'h0000_8001, 0, 2};
    tbl[5] = '{32'h5555_5555, 0, 16};

    // 1: reset with an all-ones vector presented
    rst = 1'b1; v32 = 1'b1; i32 = 32'hFFFF_FFFF; v7 = 1'b1; i7 = 7'h7F;
    step(); step();
    chk("rst_vo32", 32'(vo32), 0);     chk("rst_ready32", 32'(ready32), 1);
    chk("rst_idx32", 32'(idx32), 0);   chk("rst_last32", 32'(last32), 0);
    chk("rst_vo7", 32'(vo7), 0);       chk("rst_ready7", 32'(ready7), 1);
    rst = 1'b0;
    step();
    v32 = 1'b0; v7 = 1'b0;
    chk("post_rst_vo32", 32'(vo32), 1); chk("post_rst_idx32", 32'(idx32), 0);
    chk("post_rst_ready32", 32'(ready32), 0);
    sb32.push_back(32'hFFFF_FFFF); sb7.push_back(32'h7F);
    drain(0, 0, n, f); chk("ones32_count", n, 32);
    drain(1, 0, n, f); chk("ones7_count", n, 7);

    // 2: back-to-back pops
    send(0, 32'h8000_0011);
    chk("t2_idx0", 32'(idx32), 0); chk("t2_last0", 32'(last32), 0);
    yumi32 = 1'b1; step();
    chk("t2_idx4", 32'(idx32), 4); chk("t2_last4", 32'(last32), 0);
    step();
    chk("t2_idx31", 32'(idx32), 31); chk("t2_last31", 32'(last32), 1);
    step(); yumi32 = 1'b0;
    chk("t2_vo_end", 32'(vo32), 0); chk("t2_ready_end", 32'(ready32), 1);
    sb32.delete();

    // 3: stall holds outputs stable
    send(0, 32'h0000_0006);
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_idx", 32'(idx32), 1); chk("t3_hold_last", 32'(last32), 0);
      chk("t3_hold_vo", 32'(vo32), 1);
      step();
    end
    yumi32 = 1'b1; step();
    chk("t3_idx2", 32'(idx32), 2); chk("t3_last2", 32'(last32), 1);
    step(); yumi32 = 1'b0;
    chk("t3_ready", 32'(ready32), 1);
    sb32.delete();

    // 4: zero vector is consumed and dropped
    chk("t4_ready_pre", 32'(ready32), 1);
    send(0, 32'h0);
    chk("t4_vo", 32'(vo32), 0); chk("t4_ready", 32'(ready32), 1);
    step();
    chk("t4_vo_later", 32'(vo32), 0);
    send(0, 32'h1);
    chk("t4_idx", 32'(idx32), 0); chk("t4_last", 32'(last32), 1);
    yumi32 = 1'b1; step(); yumi32 = 1'b0;
    sb32.delete();

    // 5: reset mid-vector discards remaining bits
    send(0, 32'hFFFF_FFFF);
    yumi32 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t5_idx", 32'(idx32), k);
      step();
    end
    yumi32 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_vo", 32'(vo32), 0); chk("t5_ready", 32'(ready32), 1);
    chk("t5_idx_idle", 32'(idx32), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_no_residual", 32'(vo32), 0);
    end
    sb32.delete();

    // top bit alone at width 7
    send(1, 32'h40);
    chk("w7_top_idx", 32'(idx7), 6); chk("w7_top_last", 32'(last7), 1);
    drain(1, 0, n, f);

    // table-driven vectors
    for (int k = 0; k < 6; k++) begin
      send(0, tbl[k].vec);
      drain(0, 1, n, f);
      chk("tbl_first", f, tbl[k].first);
      chk("tbl_count", n, tbl[k].count);
    end

    // 6: random vectors with random yumi gaps
    for (int k = 0; k < 30; k++) begin
      vec = $urandom;
      if ($urandom_range(3, 0) == 0) vec = 32'd1 << $urandom_range(31, 0);
      if ($urandom_range(9, 0) == 0) vec = '0;
      send(0, vec);
      if (vec != '0) drain(0, 3, n, f);
    end
    for (int k = 0; k < 30; k++) begin
      vec = $urandom & 32'h7F;
      if ($urandom_range(3, 0) == 0) vec = 32'd1 << $urandom_range(6, 0);
      if ($urandom_range(9, 0) == 0) vec = '0;
      send(1, vec);
      if (vec != '0) drain(1, 3, n, f);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
